// File: rtl/text_display_wr_arbiter_pkg.sv
// Shared types and helpers for the text display write arbiter.
//   state_t          : transaction FSM states
//   AXI_RESP_*       : AXI write response codes
//   rr_next()        : round-robin one-hot grant search (up to MAX_REQ requesters)
package text_display_arb_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_RESP} state_t;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  localparam int MAX_REQ = 8;

  // Returns the one-hot grant for the first valid index strictly after ptr,
  // wrapping modulo n. Zero when nothing is valid.
  function automatic logic [MAX_REQ-1:0] rr_next(input logic [MAX_REQ-1:0] valid,
                                                 input logic [2:0]         ptr,
                                                 input int                 n);
    logic [MAX_REQ-1:0] g;
    logic               found;
    logic [2:0]         idx;
    g     = '0;
    found = 1'b0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      idx = 3'((int'(ptr) + k) % n);
      if ((k <= n) && !found && valid[idx]) begin
        g[idx] = 1'b1;
        found  = 1'b1;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/text_display_wr_arbiter_rr_arbiter.sv
// Round-robin arbiter with a registered last-grant pointer.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_req          : request vector
//   i_advance      : a grant is being taken this cycle; pointer moves to it
//   o_grant        : one-hot grant (combinational)
//   o_grant_idx    : binary index of o_grant
module rr_arbiter
  import text_display_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic                       i_advance,
  output logic [NUM_REQ-1:0]         o_grant,
  output logic [$clog2(NUM_REQ)-1:0] o_grant_idx
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0]   r_ptr;
  logic [MAX_REQ-1:0] w_valid;
  logic [MAX_REQ-1:0] w_oh;
  logic [IDX_W-1:0]   w_idx;

  always_comb begin
    w_valid              = '0;
    w_valid[NUM_REQ-1:0] = i_req;
  end

  assign w_oh = rr_next(w_valid, 3'(r_ptr), NUM_REQ);

  always_comb begin
    w_idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (w_oh[i]) w_idx = IDX_W'(i);
    end
  end

  assign o_grant     = w_oh[NUM_REQ-1:0];
  assign o_grant_idx = w_idx;

  // Pointer starts at the last index so requester 0 wins first after reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)       r_ptr <= IDX_W'(NUM_REQ - 1);
    else if (i_advance) r_ptr <= w_idx;
  end

endmodule

// File: rtl/text_display_wr_arbiter.sv
// Shares one AXI4-Lite write master among NUM_REQ requesters, one single-beat
// write at a time, round-robin.
//   ACLK/ARESETN        : clock, asynchronous active-low reset
//   req_valid/addr/data : per-requester request (packed, requester 0 in LSBs)
//   req_ready           : 1-cycle pulse, request captured
//   req_done/req_err    : 1-cycle pulse on B response, err when BRESP != OKAY
//   busy                : transaction in flight
//   M_AXI_*             : AXI4-Lite write channels (AW, W, B)
module text_display_wr_arbiter
  import text_display_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic                      ACLK,
  input  logic                      ARESETN,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        req_done,
  output logic [NUM_REQ-1:0]        req_err,
  output logic                      busy,
  output logic [ADDR_W-1:0]         M_AXI_AWADDR,
  output logic [2:0]                M_AXI_AWPROT,
  output logic                      M_AXI_AWVALID,
  input  logic                      M_AXI_AWREADY,
  output logic [DATA_W-1:0]         M_AXI_WDATA,
  output logic [DATA_W/8-1:0]       M_AXI_WSTRB,
  output logic                      M_AXI_WVALID,
  input  logic                      M_AXI_WREADY,
  input  logic [1:0]                M_AXI_BRESP,
  input  logic                      M_AXI_BVALID,
  output logic                      M_AXI_BREADY
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_t             r_state, w_state_nxt;
  logic [NUM_REQ-1:0] w_grant;
  logic [IDX_W-1:0]   w_grant_idx;
  logic               w_fire;
  logic [ADDR_W-1:0]  w_sel_addr;
  logic [DATA_W-1:0]  w_sel_data;
  logic               w_aw_done, w_w_done;
  logic               w_b_hs;

  logic [ADDR_W-1:0]  r_awaddr;
  logic [DATA_W-1:0]  r_wdata;
  logic               r_awvalid, r_wvalid;
  logic [NUM_REQ-1:0] r_gnt_oh;
  logic [NUM_REQ-1:0] r_req_done, r_req_err;

  // Gating with ARESETN keeps req_ready low while reset is held.
  assign w_fire = ARESETN && (r_state == ST_IDLE) && (|req_valid);

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .i_clk       (ACLK),
    .i_rst_n     (ARESETN),
    .i_req       (req_valid),
    .i_advance   (w_fire),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx)
  );

  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant_idx == IDX_W'(i)) begin
        w_sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        w_sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // A channel is complete once its VALID has dropped or is handshaking now.
  assign w_aw_done = !r_awvalid || M_AXI_AWREADY;
  assign w_w_done  = !r_wvalid  || M_AXI_WREADY;
  assign w_b_hs    = (r_state == ST_RESP) && M_AXI_BVALID;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_fire)                 w_state_nxt = ST_ADDR;
      ST_ADDR: if (w_aw_done && w_w_done)  w_state_nxt = ST_RESP;
      ST_RESP: if (M_AXI_BVALID)           w_state_nxt = ST_IDLE;
      default:                             w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_awaddr   <= '0;
      r_wdata    <= '0;
      r_awvalid  <= 1'b0;
      r_wvalid   <= 1'b0;
      r_gnt_oh   <= '0;
      r_req_done <= '0;
      r_req_err  <= '0;
    end else begin
      r_req_done <= '0;
      r_req_err  <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_fire) begin
            r_awaddr  <= w_sel_addr;
            r_wdata   <= w_sel_data;
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
            r_gnt_oh  <= w_grant;
          end
        end
        ST_ADDR: begin
          if (r_awvalid && M_AXI_AWREADY) r_awvalid <= 1'b0;
          if (r_wvalid  && M_AXI_WREADY)  r_wvalid  <= 1'b0;
        end
        ST_RESP: begin
          if (w_b_hs) begin
            r_req_done <= r_gnt_oh;
            r_req_err  <= r_gnt_oh & {NUM_REQ{M_AXI_BRESP != AXI_RESP_OKAY}};
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready     = w_grant & {NUM_REQ{w_fire}};
  assign req_done      = r_req_done;
  assign req_err       = r_req_err;
  assign busy          = (r_state != ST_IDLE);
  assign M_AXI_AWADDR  = r_awaddr;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = r_awvalid;
  assign M_AXI_WDATA   = r_wdata;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WVALID  = r_wvalid;
  assign M_AXI_BREADY  = (r_state == ST_RESP);

endmodule

// File: tb/tb_text_display_wr_arbiter.sv
// Directed bench for text_display_wr_arbiter: a single initial block drives
// requesters and a simple AXI4-Lite slave with programmable AW/W ready delays.
module tb_text_display_wr_arbiter;
  import text_display_arb_pkg::*;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            ACLK;
  logic            ARESETN;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready, req_done, req_err;
  logic            busy;
  logic [AW-1:0]   M_AXI_AWADDR;
  logic [2:0]      M_AXI_AWPROT;
  logic            M_AXI_AWVALID, M_AXI_AWREADY;
  logic [DW-1:0]   M_AXI_WDATA;
  logic [DW/8-1:0] M_AXI_WSTRB;
  logic            M_AXI_WVALID, M_AXI_WREADY;
  logic [1:0]      M_AXI_BRESP;
  logic            M_AXI_BVALID, M_AXI_BREADY;

  text_display_wr_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .req_done(req_done), .req_err(req_err), .busy(busy),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY)
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // negedge snapshots of DUT outputs
  logic [N-1:0]  s_ready, s_done, s_err;
  logic          s_busy, s_awvalid, s_wvalid, s_bready;
  logic [AW-1:0] s_awaddr;
  logic [DW-1:0] s_wdata;

  int            gnt_idx[$];
  int            gnt_cyc[$];
  int            done_cnt[N];
  logic [N-1:0]  pend_drop = '0;
  logic [N-1:0]  sticky    = '0;

  int            aw_delay = 0, w_delay = 0, aw_wait = 0, w_wait = 0;
  int            aw_hs = 0, w_hs = 0, stab_bad = 0;
  logic [1:0]    b_resp = AXI_RESP_OKAY;
  logic [AW-1:0] hs_awaddr = '0, prev_awaddr = '0;
  logic [DW-1:0] hs_wdata = '0, prev_wdata = '0;
  logic          prev_awvalid = 1'b0, prev_wvalid = 1'b0;
  int            before0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: snapshot/monitor at negedge, play slave, then update requesters
  // 1 time unit after the following posedge.
  task automatic tick();
    @(negedge ACLK);
    s_ready = req_ready;  s_done = req_done;  s_err = req_err;
    s_busy = busy;  s_awvalid = M_AXI_AWVALID;  s_wvalid = M_AXI_WVALID;
    s_bready = M_AXI_BREADY;  s_awaddr = M_AXI_AWADDR;  s_wdata = M_AXI_WDATA;
    for (int i = 0; i < N; i++) begin
      if (req_ready[i]) begin
        gnt_idx.push_back(i);
        gnt_cyc.push_back(cyc);
      end
      if (req_done[i]) done_cnt[i]++;
    end
    pend_drop = req_ready;
    if (M_AXI_AWVALID && prev_awvalid && (M_AXI_AWADDR != prev_awaddr)) stab_bad++;
    if (M_AXI_WVALID && prev_wvalid && (M_AXI_WDATA != prev_wdata)) stab_bad++;
    prev_awvalid = M_AXI_AWVALID;  prev_awaddr = M_AXI_AWADDR;
    prev_wvalid  = M_AXI_WVALID;   prev_wdata  = M_AXI_WDATA;
    if (M_AXI_AWVALID) begin
      if (aw_wait >= aw_delay) begin
        M_AXI_AWREADY = 1'b1;  aw_hs++;  hs_awaddr = M_AXI_AWADDR;  aw_wait = 0;
      end else begin
        M_AXI_AWREADY = 1'b0;  aw_wait++;
      end
    end else begin
      M_AXI_AWREADY = 1'b0;  aw_wait = 0;
    end
    if (M_AXI_WVALID) begin
      if (w_wait >= w_delay) begin
        M_AXI_WREADY = 1'b1;  w_hs++;  hs_wdata = M_AXI_WDATA;  w_wait = 0;
      end else begin
        M_AXI_WREADY = 1'b0;  w_wait++;
      end
    end else begin
      M_AXI_WREADY = 1'b0;  w_wait = 0;
    end
    if (M_AXI_BREADY) begin
      M_AXI_BVALID = 1'b1;  M_AXI_BRESP = b_resp;
    end else begin
      M_AXI_BVALID = 1'b0;  M_AXI_BRESP = 2'b00;
    end
    @(posedge ACLK);
    #1;
    req_valid = (req_valid & ~pend_drop) | (pend_drop & sticky);
    pend_drop = '0;
    cyc++;
  endtask

  task automatic wait_done();
    for (int k = 0; k < 40 && s_done == '0; k++) tick();
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
    req_valid[i] = 1'b1;
  endtask

  task automatic do_reset();
    ARESETN = 1'b0;
    tick();
    ARESETN = 1'b1;
  endtask

  initial begin
    ARESETN = 1'b0;  req_valid = '0;  req_addr = '0;  req_data = '0;
    M_AXI_AWREADY = 1'b0;  M_AXI_WREADY = 1'b0;  M_AXI_BVALID = 1'b0;  M_AXI_BRESP = 2'b00;
    for (int i = 0; i < N; i++) done_cnt[i] = 0;
    #1;
    tick();
    tick();
    // reset state
    check("rst_ctrl", {s_ready, s_done, s_err, s_busy, s_awvalid, s_wvalid, s_bready}, 64'h0);
    check("rst_awaddr", s_awaddr, 64'h0);
    check("rst_wdata", s_wdata, 64'h0);
    check("awprot_wstrb", {M_AXI_AWPROT, M_AXI_WSTRB}, {3'b000, 4'hF});
    ARESETN = 1'b1;

    // single write from requester 1
    aw_hs = 0;  w_hs = 0;
    set_req(1, 32'h10, 32'hA5);
    tick();
    check("t1_ready_c0", {s_ready, s_awvalid}, {4'b0010, 1'b0});
    tick();
    check("t1_valid_c1", {s_awvalid, s_wvalid, s_busy}, 3'b111);
    check("t1_awaddr", s_awaddr, 64'h10);
    check("t1_wdata", s_wdata, 64'hA5);
    wait_done();
    check("t1_done", {s_done, s_err}, {4'b0010, 4'b0000});
    check("t1_hs_cnt", {32'(aw_hs), 32'(w_hs)}, {32'd1, 32'd1});
    tick();

    // simultaneous requests 0 and 2 straight after reset
    do_reset();
    gnt_idx.delete();  gnt_cyc.delete();
    for (int i = 0; i < N; i++) done_cnt[i] = 0;
    set_req(0, 32'h100, 32'h1);
    set_req(2, 32'h200, 32'h2);
    for (int k = 0; k < 40 && (done_cnt[2] == 0 || busy); k++) tick();
    check("t2_ngrant", gnt_idx.size(), 2);
    check("t2_order", {gnt_idx[0][7:0], gnt_idx[1][7:0]}, {8'd0, 8'd2});
    check("t2_done_cnt", {done_cnt[0][7:0], done_cnt[2][7:0]}, {8'd1, 8'd1});

    // all requesters continuously valid
    do_reset();
    gnt_idx.delete();  gnt_cyc.delete();
    for (int i = 0; i < N; i++) set_req(i, 32'h1000 + 32'(i), 32'h50 + 32'(i));
    sticky = '1;
    for (int k = 0; k < 100 && gnt_idx.size() < 8; k++) tick();
    sticky = '0;
    for (int k = 0; k < 100 && (req_valid != '0 || busy); k++) tick();
    check("t3_ngrant_ge8", gnt_idx.size() >= 8, 1);
    for (int k = 0; k < 8; k++) begin
      if (k < gnt_idx.size()) check($sformatf("t3_grant%0d", k), gnt_idx[k], k % 4);
    end
    if (gnt_cyc.size() >= 2) check("t3_interval", gnt_cyc[1] - gnt_cyc[0], 3);

    // AW late by 3 cycles, W immediate
    tick();
    aw_hs = 0;  w_hs = 0;  aw_delay = 3;  w_delay = 0;
    set_req(2, 32'h20, 32'h5A);
    tick();
    tick();
    tick();
    check("t4a_c2_valids", {s_awvalid, s_wvalid}, 2'b10);
    wait_done();
    check("t4a_done", s_done, 4'b0100);
    check("t4a_hs", {32'(aw_hs), 32'(w_hs)}, {32'd1, 32'd1});
    check("t4a_hs_vals", {hs_awaddr, hs_wdata}, {32'h20, 32'h5A});
    tick();
    // W late by 3 cycles, AW immediate
    aw_hs = 0;  w_hs = 0;  aw_delay = 0;  w_delay = 3;
    set_req(0, 32'h30, 32'hC3);
    tick();
    tick();
    tick();
    check("t4b_c2_valids", {s_awvalid, s_wvalid}, 2'b01);
    wait_done();
    check("t4b_done", s_done, 4'b0001);
    check("t4b_hs", {32'(aw_hs), 32'(w_hs)}, {32'd1, 32'd1});
    check("t4b_hs_vals", {hs_awaddr, hs_wdata}, {32'h30, 32'hC3});
    check("t4_stable", stab_bad, 0);
    w_delay = 0;
    tick();

    // SLVERR on requester 3, then a normal write
    b_resp = AXI_RESP_SLVERR;
    set_req(3, 32'h44, 32'h77);
    wait_done();
    check("t5_err", {s_done, s_err}, {4'b1000, 4'b1000});
    tick();
    check("t5_pulse_1cyc", {s_done, s_err}, 8'h00);
    b_resp = AXI_RESP_OKAY;
    set_req(1, 32'h48, 32'h78);
    wait_done();
    check("t5_next", {s_done, s_err}, {4'b0010, 4'b0000});
    tick();

    // reset while waiting in ADDR; pending requester 0 regranted afterwards
    aw_delay = 5;
    set_req(0, 32'h40, 32'h11);
    tick();
    tick();
    check("t6_in_addr", {s_awvalid, s_busy}, 2'b11);
    before0 = done_cnt[0];
    ARESETN = 1'b0;
    req_valid[0] = 1'b1;
    tick();
    check("t6_rst_ctrl", {s_ready, s_done, s_err, s_busy, s_awvalid, s_wvalid, s_bready}, 64'h0);
    check("t6_rst_data", {s_awaddr, s_wdata}, 64'h0);
    aw_delay = 0;
    ARESETN = 1'b1;
    tick();
    check("t6_regrant", s_ready, 4'b0001);
    wait_done();
    check("t6_done", s_done, 4'b0001);
    check("t6_done_once", done_cnt[0] - before0, 1);
    check("t6_awaddr", hs_awaddr, 64'h40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
